parallel_out_sched: RTL and testbench
=====================================

# parallel_out_sched

Round-robin scheduler that shares the memory-mapped 8-bit parallel output port (address 0xFC) between several requesters. It accepts byte-write requests, grants one at a time and drives the port's EN/Address/RegData bus with a single-cycle write strobe. It then enforces a programmable hold interval, so the external device can sample each byte before the next write.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- HOLD, 4: idle cycles enforced after each write strobe, legal range 0..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  req[i] high: requester i has a byte to write.
- data  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse on the winner's bit when its byte is written.
- busy  out  1  high while a write or hold is in progress.
- EN  out  1  write strobe to the parallel output port.
- Address  out  32  32'h000000FC while EN is high, 32'h00000000 otherwise.
- RegData  out  8  byte being written; holds the last written byte otherwise.

## Operation
- Reset (rst low, asynchronous):
  - state IDLE, round-robin pointer 0.
  - EN=0, Address=0, RegData=0, ack=0, busy=0, hold counter 0.
- States: IDLE, WRITE, HOLD.
- IDLE:
  - If any req bit is high, select the winner by round-robin.
  - Search starts at the pointer and goes pointer, pointer+1, ... modulo NREQ; the first high req bit wins.
  - Latch the winner's data byte and winner index, then go to WRITE.
  - If no req bit is high, stay in IDLE.
- WRITE (exactly one cycle):
  - EN=1, Address=32'h000000FC, RegData=latched byte, ack[winner]=1, busy=1.
  - Update pointer to (winner+1) mod NREQ.
  - If HOLD=0, go to IDLE; otherwise load counter with HOLD and go to HOLD.
- HOLD:
  - EN=0, busy=1; decrement the counter each cycle.
  - Leave for IDLE in the cycle the counter reaches 0, so HOLD lasts exactly HOLD cycles.
- Data capture:
  - data is sampled only in the IDLE grant cycle.
  - Requester changes to data or req after that have no effect on the write in progress.
  - Dropping req after grant does not cancel the write; ack still pulses.
- Requester rule: after ack, a requester must deassert req or present its next byte. A req still high in the next IDLE cycle is a new request.
- No ack is issued without a matching EN pulse in the same cycle. At most one ack bit is high per cycle.

## Timing
- Request sampled in IDLE cycle N:
  - EN and ack high in cycle N+1.
  - Port DataOut updates at the end of cycle N+1.
- busy:
  - Rises in cycle N+1 and stays high for 1+HOLD cycles.
  - Low in IDLE, including the grant cycle N.
- Minimum spacing between consecutive EN pulses is HOLD+2 cycles (one IDLE, one WRITE, HOLD cycles).
- With all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. A requester waits at most NREQ-1 other writes.
- Reset mid-WRITE or mid-HOLD:
  - Outputs clear immediately and asynchronously.
  - An aborted WRITE cycle produces no ack after reset release.
  - The first grant after release uses pointer 0.
- Reset release: the first grant occurs no earlier than the first rising edge with rst high.

## Test plan
- HOLD=4, req[0]=1 with data byte 8'hA5 in IDLE:
  - Next cycle: EN=1, Address=32'h000000FC, RegData=8'hA5, ack=2'b01.
  - busy high for 5 cycles, then IDLE.
  - Port DataOut reads 8'hA5.
- HOLD=4, req=2'b11 held continuously, data bytes 8'h11 (req 0) and 8'h22 (req 1):
  - EN pulses every 6 cycles.
  - RegData sequence 8'h11, 8'h22, 8'h11, 8'h22; ack alternates 01, 10.
- Fairness: req[1] alone is granted, then req=2'b11 → the next grant goes to requester 0 (pointer wrapped to 0).
- Grant cycle with data byte 8'h3C, then req dropped and data changed to 8'hFF → write still uses 8'h3C and ack pulses.
- HOLD=0, req[0] held continuously → EN pulses every 2 cycles, busy high 1 cycle per write.
- rst pulsed low during HOLD:
  - All outputs 0 immediately, no further ack.
  - After release, req=2'b10 → requester 1 is granted on the first IDLE cycle.

Source files
------------

// File: rtl/parallel_out_sched.sv
// Round-robin arbiter for the byte-wide parallel output port at 0xFC.
// One write strobe per grant, followed by a fixed hold interval so the device can sample.
module parallel_out_sched #(
  parameter int NREQ = 2,
  parameter int HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   data,
  output logic [NREQ-1:0]     ack,
  output logic                busy,
  output logic                EN,
  output logic [31:0]         Address,
  output logic [7:0]          RegData
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_winner;
  logic [7:0]    r_byte;
  logic [7:0]    r_cnt;

  logic          w_any;
  logic [IW-1:0] w_win;
  logic [7:0]    w_win_byte;
  int            w_idx;

  // Scan pointer, pointer+1, ... modulo NREQ; the first requester found wins.
  always_comb begin
    w_any      = 1'b0;
    w_win      = r_ptr;
    w_idx      = 0;
    w_win_byte = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = IW'(w_idx);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == w_win) w_win_byte = data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_byte   <= 8'h00;
      r_cnt    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_winner <= w_win;
            r_byte   <= w_win_byte;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_winner == IW'(NREQ - 1)) r_ptr <= '0;
          else                           r_ptr <= r_winner + 1'b1;
          if (HOLD == 0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= 8'(HOLD);
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt - 8'd1;
          // Count HOLD..1 so the hold spans exactly HOLD cycles.
          if (r_cnt == 8'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign EN      = (r_state == S_WRITE);
  assign busy    = (r_state != S_IDLE);
  assign Address = EN ? 32'h0000_00FC : 32'h0000_0000;
  assign RegData = r_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack[gi] = EN && (r_winner == IW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_parallel_out_sched.sv
// Scoreboard bench for parallel_out_sched: stimulus queues expected writes, a monitor checks each EN.
module tb_parallel_out_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, ack, req0, ack0;
  logic [15:0] data, data0;
  logic        busy, EN, busy0, EN0;
  logic [31:0] Address, Address0;
  logic [7:0]  RegData, RegData0;

  parallel_out_sched #(.NREQ(2), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .busy(busy),
    .EN(EN), .Address(Address), .RegData(RegData)
  );

  parallel_out_sched #(.NREQ(2), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .data(data0), .ack(ack0), .busy(busy0),
    .EN(EN0), .Address(Address0), .RegData(RegData0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic [1:0] a;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_w(input logic [7:0] b, input logic [1:0] a, input int gap);
    exp_t e;
    e.b = b; e.a = a; e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: every EN pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (EN === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got RegData %0h ack %b expected no write", RegData, ack);
        end else begin
          e = sb.pop_front();
          chk("sb_regdata", 32'(RegData), 32'(e.b));
          chk("sb_ack", 32'(ack), 32'(e.a));
          chk("sb_address", Address, 32'h0000_00FC);
          if (e.gap != 0) chk("sb_gap", 32'(cyc - last_en), 32'(e.gap));
          $display("write: RegData=%0h ack=%b cycle=%0d", RegData, ack, cyc);
        end
        last_en = cyc;
      end else begin
        chk("idle_ack", 32'(ack), 32'h0);
        chk("idle_address", Address, 32'h0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic wait_en();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!EN && n < 50);
    if (!EN) chk("en_timeout", 32'(EN), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; req = 2'b00; data = 16'h0; req0 = 2'b00; data0 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(EN), 32'h0);
    chk("rst_address", Address, 32'h0);
    chk("rst_regdata", 32'(RegData), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk); rst = 1'b1;

    // Both requesting continuously: alternating grants, 6-cycle spacing.
    @(posedge clk); #1;
    data = {8'h22, 8'h11}; req = 2'b11;
    expect_w(8'h11, 2'b01, 0);
    expect_w(8'h22, 2'b10, 6);
    expect_w(8'h11, 2'b01, 6);
    expect_w(8'h22, 2'b10, 6);
    for (int i = 0; i < 4; i++) wait_en();
    req = 2'b00;

    // Single write: busy for exactly 1+HOLD cycles.
    wait_idle();
    data[7:0] = 8'hA5; req = 2'b01;
    expect_w(8'hA5, 2'b01, 0);
    @(posedge clk); #1;
    req = 2'b00;
    chk("t1_en", 32'(EN), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("t1_busy", 32'(busy), 32'h1);
      @(posedge clk); #1;
    end
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_regdata_hold", 32'(RegData), 32'hA5);

    // Fairness: after requester 1 wins, the pointer wraps to 0.
    wait_idle();
    data[15:8] = 8'h5A; req = 2'b10;
    expect_w(8'h5A, 2'b10, 0);
    wait_en();
    data[7:0] = 8'h77; req = 2'b11;
    expect_w(8'h77, 2'b01, 6);
    wait_en();
    req = 2'b00;

    // Data captured at grant; later changes and dropped req are ignored.
    wait_idle();
    data[7:0] = 8'h3C; req = 2'b01;
    expect_w(8'h3C, 2'b01, 0);
    @(posedge clk); #1;
    req = 2'b00; data[7:0] = 8'hFF;
    wait_idle();
    chk("cap_regdata_hold", 32'(RegData), 32'h3C);

    // Reset during HOLD clears outputs at once and the pointer returns to 0.
    wait_idle();
    data[7:0] = 8'h44; req = 2'b01;
    expect_w(8'h44, 2'b01, 0);
    wait_en();
    req = 2'b00;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_en", 32'(EN), 32'h0);
    chk("arst_address", Address, 32'h0);
    chk("arst_regdata", 32'(RegData), 32'h0);
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    data = {8'h66, 8'h55}; req = 2'b11;
    expect_w(8'h55, 2'b01, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_en", 32'(EN), 32'h1);
    chk("post_rst_ack", 32'(ack), 32'h1);
    req = 2'b00;
    wait_idle();
    data[15:8] = 8'h99; req = 2'b10;
    expect_w(8'h99, 2'b10, 0);
    wait_en();
    req = 2'b00;

    // HOLD=0 instance: a write every other cycle while req stays high.
    @(posedge clk); #1;
    data0 = {8'h00, 8'hC3}; req0 = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("h0_en", 32'(EN0), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("h0_busy", 32'(busy0), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("h0_ack", 32'(ack0), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 0) begin
        chk("h0_regdata", 32'(RegData0), 32'hC3);
        $display("write(HOLD=0): RegData=%0h ack=%b cycle=%0d", RegData0, ack0, cyc);
      end
    end
    req0 = 2'b00;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
